sn_window_counter: RTL and testbench
====================================

SN_WINDOW_COUNTER -- requirements
Module: sn_window_counter

Interface
REQ-001 SHALL have parameter MAX_LOG2, default 11, giving the log2 of the largest window length.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-high (port name kept as the codebase names it).
REQ-004 SHALL have port start, input, 1 bit: arms one measurement when the block is in IDLE.
REQ-005 SHALL have port cont, input, 1 bit: continuous mode; sampled together with start.
REQ-006 SHALL have port win_sel, input, 3 bits: window length N = 2^(win_sel+4), clamped to 2^MAX_LOG2; sampled together with start.
REQ-007 SHALL have port sn_bit, input, 1 bit: stochastic bitstream sample, e.g. the XNOR multiplier output.
REQ-008 SHALL have port sn_valid, input, 1 bit: sn_bit is valid this cycle.
REQ-009 SHALL have port ones, output, MAX_LOG2+1 bits: count of 1s in the completed window.
REQ-010 SHALL have port bipolar, output, MAX_LOG2+2 bits signed: 2*ones - N.
REQ-011 SHALL have port out_valid, output, 1 bit: result available.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port busy, output, 1 bit: high while in COUNT.
REQ-014 SHALL have port overrun, output, 1 bit: sticky flag, set when valid samples are dropped.

Function
REQ-015 SHALL implement the states IDLE, COUNT and DONE.
REQ-016 In IDLE with start=1, the block SHALL latch win_sel and cont, clear the sample and ones counters, and enter COUNT on the next cycle.
REQ-017 In COUNT, each cycle with sn_valid=1 SHALL increment the sample counter and add sn_bit to the ones counter; cycles with sn_valid=0 SHALL change nothing.
REQ-018 When the N-th valid sample is consumed, the block SHALL, on the next edge, register ones (including that N-th bit) and bipolar, assert out_valid, and enter DONE; latency from the N-th sample to out_valid is 1 cycle.
REQ-019 ones SHALL never wrap: its width holds 0..2^MAX_LOG2 inclusive, so an all-ones window gives ones=N.
REQ-020 bipolar SHALL be computed in full signed width: ones=0 gives -N; ones=N gives +N.
REQ-021 In DONE, ones, bipolar and out_valid SHALL hold stable until out_ready=1.
REQ-022 A handshake (out_valid and out_ready both 1) SHALL deassert out_valid on the next cycle.
REQ-023 On handshake, the next state SHALL be COUNT with cleared counters if the latched cont=1, otherwise IDLE.
REQ-024 A valid sample arriving in DONE in the same cycle as the handshake SHALL be dropped and is not counted in the next window.
REQ-025 A sample with sn_valid=1 arriving in DONE SHALL be dropped and SHALL set overrun; overrun clears only on reset or on start accepted in IDLE.
REQ-026 start in COUNT or DONE SHALL be ignored; win_sel and cont changes mid-window SHALL have no effect.
REQ-027 win_sel values above MAX_LOG2-4 SHALL select N = 2^MAX_LOG2.
REQ-028 busy SHALL equal (state==COUNT).

Reset
REQ-029 rst_n=1 at a rising edge SHALL force IDLE, all counters to 0, ones=0, bipolar=0, out_valid=0 and overrun=0, in any state, including mid-window and DONE (a pending result is discarded).
REQ-030 No output SHALL change asynchronously with rst_n.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE/COUNT/DONE), the MAX_LOG2 default, and the window-length decode function from win_sel to N.
REQ-032 The datapath SHALL be one sub-module, sn_ones_accum (sample and ones counters with clear/enable and a terminal-count flag); the FSM and output registers SHALL live in the top module.

Verification
REQ-033 Reset, then start with win_sel=0, cont=0, and 16 valid samples all 1 -> ones=16, bipolar=+16, out_valid 1 cycle after the 16th sample; after the handshake, state is IDLE.
REQ-034 win_sel=1 (N=32), alternating 1/0 with sn_valid toggling every other cycle -> ones=16, bipolar=0, out_valid only after the 32nd valid sample.
REQ-035 N=16, all-zero stream, out_ready held 0 for 5 cycles with sn_valid=1 -> ones=0 and bipolar=-16 stable throughout; overrun=1; next start clears overrun.
REQ-036 cont=1, win_sel=0, out_ready tied 1, continuous 0xFFFF-then-0x0000 pattern -> successive results 16 then 0; the bit coincident with each handshake is dropped.
REQ-037 win_sel=7 with MAX_LOG2=11 -> N=2048; all-ones stream gives ones=2048 and bipolar=+2048 with no wrap.
REQ-038 rst_n pulsed at sample 10 of a 16-sample window -> all outputs 0 and IDLE next cycle; a fresh start yields a correct full-window count.

Source files
------------

// File: rtl/sn_window_counter_pkg.sv
// Shared types, defaults and window-length decode for the stochastic window counter.
package sn_window_counter_pkg;

  localparam int unsigned MAX_LOG2_DEFAULT = 11;
  localparam int unsigned MIN_LOG2         = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Window length N = 2^(win_sel+4), clamped to 2^max_log2.
  function automatic int unsigned win_len(input logic [2:0] win_sel,
                                          input int unsigned max_log2);
    int unsigned l2;
    l2 = 32'(win_sel) + MIN_LOG2;
    if (l2 > max_log2) l2 = max_log2;
    return 32'd1 << l2;
  endfunction

endpackage

// File: rtl/sn_ones_accum.sv
// Sample and ones counters for one measurement window, with terminal-count detect.
module sn_ones_accum
  import sn_window_counter_pkg::*;
#(
  parameter int unsigned MAX_LOG2 = MAX_LOG2_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_en,
  input  logic              i_bit,
  input  logic [MAX_LOG2:0] i_n,
  output logic [MAX_LOG2:0] o_ones_next_c,
  output logic              o_term_c
);

  localparam int unsigned CW = MAX_LOG2 + 1;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_ones;

  // Ones count including the sample being consumed this cycle.
  assign o_ones_next_c = r_ones + CW'(i_bit);

  // Terminal count: the N-th valid sample is being consumed now.
  assign o_term_c = i_en && (r_cnt == (i_n - CW'(1)));

  // Counters; rst_n is an active-high synchronous reset, clear wins over enable.
  always_ff @(posedge clk) begin
    if (rst_n || i_clear) begin
      r_cnt  <= '0;
      r_ones <= '0;
    end else if (i_en) begin
      r_cnt  <= r_cnt + CW'(1);
      r_ones <= o_ones_next_c;
    end
  end

endmodule

// File: rtl/sn_window_counter.sv
// Windowed ones counter for stochastic bitstreams with valid/ready result output.
module sn_window_counter
  import sn_window_counter_pkg::*;
#(
  parameter int unsigned MAX_LOG2 = MAX_LOG2_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       cont,
  input  logic [2:0]                 win_sel,
  input  logic                       sn_bit,
  input  logic                       sn_valid,
  output logic [MAX_LOG2:0]          ones,
  output logic signed [MAX_LOG2+1:0] bipolar,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       overrun
);

  localparam int unsigned CW = MAX_LOG2 + 1;
  localparam int unsigned BW = MAX_LOG2 + 2;

  state_t               r_state;
  logic                 r_cont;
  logic                 r_busy;
  logic                 r_out_valid;
  logic                 r_overrun;
  logic [CW-1:0]        r_n;
  logic [CW-1:0]        r_ones;
  logic signed [BW-1:0] r_bipolar;

  logic                 w_start_acc;
  logic                 w_handshake;
  logic                 w_en;
  logic                 w_clear;
  logic                 w_term;
  logic [CW-1:0]        w_n;
  logic [CW-1:0]        w_ones_next;
  logic signed [BW-1:0] w_bipolar;

  assign w_n         = CW'(win_len(win_sel, MAX_LOG2));
  assign w_start_acc = (r_state == IDLE) && start;
  assign w_handshake = (r_state == DONE) && out_ready;
  assign w_en        = (r_state == COUNT) && sn_valid;
  // Counters restart on a new start, on completing a window, and on a continuous re-arm.
  assign w_clear     = w_start_acc || w_term || (w_handshake && r_cont);
  // 2*ones - N in modular BW-bit arithmetic; the true range -N..+N fits signed BW bits.
  assign w_bipolar   = $signed((BW'(w_ones_next) << 1) - BW'(r_n));

  sn_ones_accum #(
    .MAX_LOG2 (MAX_LOG2)
  ) u_accum (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clear       (w_clear),
    .i_en          (w_en),
    .i_bit         (sn_bit),
    .i_n           (r_n),
    .o_ones_next_c (w_ones_next),
    .o_term_c      (w_term)
  );

  // Control FSM and result registers; rst_n is an active-high synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_cont      <= 1'b0;
      r_n         <= '0;
      r_ones      <= '0;
      r_bipolar   <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_cont    <= cont;
            r_n       <= w_n;
            r_overrun <= 1'b0;
            r_state   <= COUNT;
            r_busy    <= 1'b1;
          end
        end
        COUNT: begin
          if (w_term) begin
            r_ones      <= w_ones_next;
            r_bipolar   <= w_bipolar;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
            r_busy      <= 1'b0;
          end
        end
        DONE: begin
          // Samples arriving while a result is pending are lost.
          if (sn_valid) r_overrun <= 1'b1;
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_cont) begin
              r_state <= COUNT;
              r_busy  <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ones      = r_ones;
  assign bipolar   = r_bipolar;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_sn_window_counter.sv
// Self-checking bench for sn_window_counter with a result scoreboard.
module tb_sn_window_counter;

  localparam int unsigned ML = 11;

  typedef struct {
    logic [ML:0]          ones;
    logic signed [ML+1:0] bip;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic                 cont;
  logic [2:0]           win_sel;
  logic                 sn_bit;
  logic                 sn_valid;
  logic [ML:0]          ones;
  logic signed [ML+1:0] bipolar;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;
  logic                 overrun;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t e_mon;
  logic prev_ov = 1'b0;

  int   m_n;
  int   m_cnt;
  int   m_ones;

  sn_window_counter #(.MAX_LOG2(ML)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cont      (cont),
    .win_sel   (win_sel),
    .sn_bit    (sn_bit),
    .sn_valid  (sn_valid),
    .ones      (ones),
    .bipolar   (bipolar),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Pop and compare one expected result on every new out_valid assertion.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && prev_ov !== 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: ones=%0d bipolar=%0d but no result expected", ones, bipolar);
      end else begin
        e_mon = sb.pop_front();
        if (ones !== e_mon.ones || bipolar !== e_mon.bip) begin
          errors++;
          $display("FAIL sb_result: ones=%0d bipolar=%0d expected ones=%0d bipolar=%0d",
                   ones, bipolar, e_mon.ones, e_mon.bip);
        end
      end
    end
    prev_ov = out_valid;
  end

  // Drive one sample cycle; counted samples feed the model, which pushes at window end.
  task automatic feed(input logic b, input logic v, input logic counted);
    sn_bit   = b;
    sn_valid = v;
    if (v && counted) begin
      m_cnt++;
      m_ones += int'(b);
      if (m_cnt == m_n) begin
        sb.push_back(exp_t'{ones: (ML+1)'(m_ones), bip: (ML+2)'(2 * m_ones - m_n)});
        m_cnt  = 0;
        m_ones = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_start(input logic [2:0] ws, input logic c, input int n);
    start    = 1'b1;
    win_sel  = ws;
    cont     = c;
    sn_valid = 1'b0;
    m_n      = n;
    m_cnt    = 0;
    m_ones   = 0;
    @(negedge clk);
    start   = 1'b0;
    win_sel = 3'd0;
    cont    = ~c;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL start_busy: busy=%b expected 1", busy);
    end
  endtask

  task automatic handshake(input logic exp_busy);
    out_ready = 1'b1;
    sn_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== exp_busy) begin
      errors++;
      $display("FAIL handshake: out_valid=%b busy=%b expected out_valid=0 busy=%b",
               out_valid, busy, exp_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; cont = 1'b0; win_sel = 3'd0;
    sn_bit = 1'b0; sn_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 ||
        ones !== '0 || bipolar !== '0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b busy=%b overrun=%b ones=%0d bipolar=%0d expected all 0",
               out_valid, busy, overrun, ones, bipolar);
    end
  endtask

  task automatic test_all_ones_16();
    do_start(3'd0, 1'b0, 16);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL ones16_early: out_valid=%b expected 0 before 16th sample", out_valid);
        end
      end
      feed(1'b1, 1'b1, 1'b1);
    end
    sn_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || ones !== 12'd16 || bipolar !== 13'sd16) begin
      errors++;
      $display("FAIL ones16_latency: out_valid=%b ones=%0d bipolar=%0d expected 1 16 16",
               out_valid, ones, bipolar);
    end
    handshake(1'b0);
  endtask

  task automatic test_alternating_32();
    int k;
    k = 0;
    do_start(3'd1, 1'b0, 32);
    for (int i = 0; i < 63; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL alt32_early: out_valid=%b at cycle %0d expected 0", out_valid, i);
      end
      if (i % 2 == 0) begin
        feed((k % 2 == 0) ? 1'b1 : 1'b0, 1'b1, 1'b1);
        k++;
      end else begin
        feed(1'b1, 1'b0, 1'b1);
      end
    end
    sn_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || ones !== 12'd16 || bipolar !== 13'sd0) begin
      errors++;
      $display("FAIL alt32_result: out_valid=%b ones=%0d bipolar=%0d expected 1 16 0",
               out_valid, ones, bipolar);
    end
    handshake(1'b0);
  endtask

  task automatic test_hold_overrun();
    do_start(3'd0, 1'b0, 16);
    for (int i = 0; i < 16; i++) feed(1'b0, 1'b1, 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || ones !== 12'd0 || bipolar !== -13'sd16) begin
        errors++;
        $display("FAIL hold_stable: out_valid=%b ones=%0d bipolar=%0d expected 1 0 -16",
                 out_valid, ones, bipolar);
      end
      feed(1'b1, 1'b1, 1'b0);
    end
    sn_valid = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: overrun=%b expected 1", overrun);
    end
    handshake(1'b0);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: overrun=%b expected 1", overrun);
    end
    // Fresh start clears overrun; start/win_sel/cont changes mid-window are ignored.
    do_start(3'd0, 1'b0, 16);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: overrun=%b expected 0", overrun);
    end
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin start = 1'b1; win_sel = 3'd7; cont = 1'b1; end
      if (i == 9) begin start = 1'b0; win_sel = 3'd0; cont = 1'b0; end
      feed(1'($urandom_range(0, 1)), 1'b1, 1'b1);
    end
    sn_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midwin_ignore: out_valid=%b expected 1 after 16 samples", out_valid);
    end
    handshake(1'b0);
  endtask

  task automatic test_continuous();
    logic b;
    do_start(3'd0, 1'b1, 16);
    out_ready = 1'b1;
    for (int w = 0; w < 3; w++) begin
      b = (w == 1) ? 1'b0 : 1'b1;
      for (int i = 0; i < 16; i++) feed(b, 1'b1, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL cont_done: window %0d out_valid=%b busy=%b expected 1 0", w, out_valid, busy);
      end
      feed(1'b1, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL cont_rearm: window %0d out_valid=%b busy=%b expected 0 1", w, out_valid, busy);
      end
    end
    sn_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL cont_overrun: overrun=%b expected 1", overrun);
    end
  endtask

  task automatic test_max_window();
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL max_reset: busy=%b out_valid=%b expected 0 0", busy, out_valid);
    end
    do_start(3'd7, 1'b0, 2048);
    for (int i = 0; i < 2048; i++) begin
      if (i == 2047) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL max_early: out_valid=%b expected 0", out_valid);
        end
      end
      feed(1'b1, 1'b1, 1'b1);
    end
    sn_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || ones !== 12'd2048 || bipolar !== 13'sd2048) begin
      errors++;
      $display("FAIL max_result: out_valid=%b ones=%0d bipolar=%0d expected 1 2048 2048",
               out_valid, ones, bipolar);
    end
    handshake(1'b0);
  endtask

  task automatic test_reset_mid();
    do_start(3'd0, 1'b0, 16);
    for (int i = 0; i < 9; i++) feed(1'b1, 1'b1, 1'b1);
    rst_n    = 1'b1;
    sn_bit   = 1'b1;
    sn_valid = 1'b1;
    @(negedge clk);
    rst_n    = 1'b0;
    sn_valid = 1'b0;
    m_cnt    = 0;
    m_ones   = 0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || overrun !== 1'b0 ||
        ones !== '0 || bipolar !== '0) begin
      errors++;
      $display("FAIL midreset_state: busy=%b out_valid=%b overrun=%b ones=%0d bipolar=%0d expected all 0",
               busy, out_valid, overrun, ones, bipolar);
    end
    do_start(3'd0, 1'b0, 16);
    for (int i = 0; i < 16; i++) feed(1'($urandom_range(0, 1)), 1'b1, 1'b1);
    sn_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_fresh: out_valid=%b expected 1", out_valid);
    end
    handshake(1'b0);
  endtask

  initial begin
    test_reset();
    test_all_ones_16();
    test_alternating_32();
    test_hold_overrun();
    test_continuous();
    test_max_window();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d results outstanding expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
